// File: rtl/fft_addr_gen.sv
// fft_addr_gen: address/twiddle sequencer for an in-place radix-2 DIT FFT.
// It walks LOG2N stages of N/2 butterflies each. For every butterfly it
// emits the operand addresses a/b and the twiddle-ROM index. Input data is
// expected in bit-reversed order.
// Optional feature: define FFT_STAGE_DRAIN_EN to insert DRAIN_CYCLES idle
// cycles between stages. This gives the butterfly pipeline time to write
// its results back before the next stage reads them.
module fft_addr_gen #(
    parameter int LOG2N        = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [LOG2N-1:0]         addr_a_o,
    output logic [LOG2N-1:0]         addr_b_o,
    output logic [LOG2N-2:0]         tw_idx_o,
    output logic [$clog2(LOG2N)-1:0] stage_o,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [KW-1:0]   k_r, k_s;
    logic [SW-1:0]   s_r, s_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            valid_r, valid_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            last_r, last_s;
    logic [LOG2N-1:0] addr_a_r, addr_a_s;
    logic [LOG2N-1:0] addr_b_r, addr_b_s;
    logic [KW-1:0]   tw_r, tw_s;
    logic [SW-1:0]   stage_r, stage_s;
    logic            xfer_s;

    // Operand a address: k with a zero bit inserted at position s.
    function automatic logic [LOG2N-1:0] calc_addr_a(input logic [KW-1:0] k,
                                                     input logic [SW-1:0] s);
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] hi;
        kx   = {1'b0, k};
        mask = (LOG2N'(1) << s) - LOG2N'(1);
        hi   = (kx >> s) << (int'(s) + 1);
        return hi | (kx & mask);
    endfunction

    // Twiddle index: position within the butterfly group, scaled to W_N.
    function automatic logic [KW-1:0] calc_tw(input logic [KW-1:0] k,
                                              input logic [SW-1:0] s);
        logic [KW-1:0] mask;
        mask = KW'((LOG2N'(1) << s) - LOG2N'(1));
        return (k & mask) << (LOG2N - 1 - int'(s));
    endfunction

    // Next-state, counter and output-value logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        s_s     = s_r;
        cnt_s   = cnt_r;
        valid_s = valid_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        xfer_s  = valid_r & ready_i;
        case (state_r)
            ST_IDLE: begin
                k_s = {KW{1'b0}};
                s_s = {SW{1'b0}};
                if (start_i) begin
                    state_s = ST_RUN;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                end else begin
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            ST_RUN: begin
                valid_s = 1'b1;
                busy_s  = 1'b1;
                if (xfer_s) begin
                    if (k_r == K_LAST) begin
                        k_s = {KW{1'b0}};
                        if (s_r == S_LAST) begin
                            state_s = ST_IDLE;
                            s_s     = {SW{1'b0}};
                            valid_s = 1'b0;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            s_s = s_r + SW'(1);
`ifdef FFT_STAGE_DRAIN_EN
                            state_s = ST_DRAIN;
                            cnt_s   = {CW{1'b0}};
                            valid_s = 1'b0;
`else
                            state_s = ST_RUN;
`endif
                        end
                    end else begin
                        k_s = k_r + KW'(1);
                    end
                end else begin
                    k_s = k_r;
                end
            end
`ifdef FFT_STAGE_DRAIN_EN
            ST_DRAIN: begin
                busy_s  = 1'b1;
                valid_s = 1'b0;
                if (cnt_r == CW'(DRAIN_CYCLES - 1)) begin
                    state_s = ST_RUN;
                    valid_s = 1'b1;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                k_s     = {KW{1'b0}};
                s_s     = {SW{1'b0}};
                cnt_s   = {CW{1'b0}};
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        if (busy_s) begin
            addr_a_s = calc_addr_a(k_s, s_s);
            addr_b_s = calc_addr_a(k_s, s_s) + (LOG2N'(1) << s_s);
            tw_s     = calc_tw(k_s, s_s);
            stage_s  = s_s;
            last_s   = (k_s == K_LAST);
        end else begin
            addr_a_s = {LOG2N{1'b0}};
            addr_b_s = {LOG2N{1'b0}};
            tw_s     = {KW{1'b0}};
            stage_s  = {SW{1'b0}};
            last_s   = 1'b0;
        end
    end

    // State, counters and registered outputs; reset aborts any transform.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            k_r      <= {KW{1'b0}};
            s_r      <= {SW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            last_r   <= 1'b0;
            addr_a_r <= {LOG2N{1'b0}};
            addr_b_r <= {LOG2N{1'b0}};
            tw_r     <= {KW{1'b0}};
            stage_r  <= {SW{1'b0}};
        end else begin
            state_r  <= state_s;
            k_r      <= k_s;
            s_r      <= s_s;
            cnt_r    <= cnt_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            last_r   <= last_s;
            addr_a_r <= addr_a_s;
            addr_b_r <= addr_b_s;
            tw_r     <= tw_s;
            stage_r  <= stage_s;
        end
    end

    assign valid_o  = valid_r;
    assign addr_a_o = addr_a_r;
    assign addr_b_o = addr_b_r;
    assign tw_idx_o = tw_r;
    assign stage_o  = stage_r;
    assign last_o   = last_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;

endmodule
